// File: rtl/uart_pkg.sv
// Shared UART definitions: baud controller FSM states and default rate parameters.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int MIN_DIV_DEF    = 256;

  typedef enum logic [1:0] {
    ST_OFF,
    ST_LOAD,
    ST_RUN,
    ST_WAIT_IDLE
  } baud_state_t;

endpackage

// File: rtl/baud_rate_generator.sv
// Fractional baud generator: toggles baud_out every divisor/128 clocks (25.7 fixed point).
// The target is captured while disabled, so the rate cannot change mid-run.
module baud_rate_generator (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] divisor,
  output logic        baud_out
);

  logic [31:0] target;
  logic [32:0] acc;
  logic [32:0] acc_next;

  // Each clock adds one whole clock (128 in 1/128 units) to the phase accumulator.
  assign acc_next = acc + 33'd128;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      baud_out <= 1'b0;
      target   <= '0;
    end else if (!enable) begin
      acc      <= '0;
      baud_out <= 1'b0;
      target   <= divisor;
    end else if (acc_next >= {1'b0, target}) begin
      acc      <= acc_next - {1'b0, target};
      baud_out <= ~baud_out;
    end else begin
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/baud_ctrl.sv
// Baud rate controller: accepts divisor/enable requests, defers rate changes while a
// frame is in flight, and derives tick_16x / tick_bit from the fractional generator.
module baud_ctrl
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int MIN_DIV    = MIN_DIV_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [31:0] cfg_divisor,
  input  logic        cfg_enable,
  input  logic        link_busy,
  output logic        cfg_err,
  output logic        active,
  output logic        pending,
  output logic [31:0] cur_divisor,
  output logic        tick_16x,
  output logic        tick_bit
);

  localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);

  // Handshake: a request is taken on any cycle where cfg_valid && cfg_ready;
  // cfg_ready depends only on state, never on cfg_valid.
  baud_state_t state;
  logic [31:0] pend_div;
  logic        pend_en;
  logic        gen_en;
  logic        baud_out;
  logic        baud_q;
  logic [CW-1:0] cnt;
  logic        accept;
  logic        bad_div;

  assign gen_en    = (state == ST_RUN) || (state == ST_WAIT_IDLE);
  assign active    = gen_en;
  assign cfg_ready = (state == ST_OFF) || (state == ST_RUN);
  assign pending   = (state == ST_WAIT_IDLE);
  assign accept    = cfg_valid && cfg_ready;
  assign bad_div   = cfg_divisor < 32'(MIN_DIV);
  assign tick_16x  = gen_en && baud_out && !baud_q;
  assign tick_bit  = tick_16x && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_OFF;
      cur_divisor <= 32'(MIN_DIV);
      pend_div    <= '0;
      pend_en     <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      cfg_err <= accept && bad_div;
      case (state)
        ST_OFF: begin
          if (accept && !bad_div) begin
            cur_divisor <= cfg_divisor;
            if (cfg_enable) state <= ST_LOAD;
          end
        end
        ST_LOAD: state <= ST_RUN;
        ST_RUN: begin
          if (accept && !bad_div) begin
            if (!link_busy) begin
              cur_divisor <= cfg_divisor;
              state       <= cfg_enable ? ST_LOAD : ST_OFF;
            end else begin
              pend_div <= cfg_divisor;
              pend_en  <= cfg_enable;
              state    <= ST_WAIT_IDLE;
            end
          end
        end
        ST_WAIT_IDLE: begin
          if (!link_busy) begin
            cur_divisor <= pend_div;
            pend_div    <= '0;
            pend_en     <= 1'b0;
            state       <= pend_en ? ST_LOAD : ST_OFF;
          end
        end
        default: state <= ST_OFF;
      endcase
    end
  end

  // Edge register and tick counter restart whenever the generator is stopped.
  always_ff @(posedge clk) begin
    if (reset || !gen_en) baud_q <= 1'b0;
    else                  baud_q <= baud_out;

    if (reset || state == ST_OFF || state == ST_LOAD) cnt <= '0;
    else if (tick_16x) cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
  end

  baud_rate_generator u_gen (
    .clk      (clk),
    .reset    (reset),
    .enable   (gen_en),
    .divisor  (cur_divisor),
    .baud_out (baud_out)
  );

endmodule

// File: tb/tb_baud_ctrl.sv
// Bench for baud_ctrl: tick times predicted from run segments (start, end, divisor).
module tb_baud_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_divisor;
  logic        cfg_enable;
  logic        link_busy;
  logic        cfg_err;
  logic        active;
  logic        pending;
  logic [31:0] cur_divisor;
  logic        tick_16x;
  logic        tick_bit;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int err_pulses = 0;
  int got16[$];
  int gotb[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_bit_q[$];

  always #5 clk = ~clk;

  baud_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_divisor (cfg_divisor),
    .cfg_enable  (cfg_enable),
    .link_busy   (link_busy),
    .cfg_err     (cfg_err),
    .active      (active),
    .pending     (pending),
    .cur_divisor (cur_divisor),
    .tick_16x    (tick_16x),
    .tick_bit    (tick_bit)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (tick_16x) got16.push_back(cyc);
    if (tick_bit) gotb.push_back(cyc);
    if (cfg_err) err_pulses++;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic clear_obs();
    got16.delete();
    gotb.delete();
    exp_q.delete();
    exp_bit_q.delete();
    err_pulses = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cfg_valid = 1'b0;
    cfg_divisor = '0;
    cfg_enable = 1'b0;
    link_busy = 1'b0;
    steps(2);
    reset = 1'b0;
  endtask

  task automatic start_run(input int d, input logic busy_v, output int rs);
    cfg_valid = 1'b1;
    cfg_divisor = d;
    cfg_enable = 1'b1;
    link_busy = busy_v;
    step();
    cfg_valid = 1'b0;
    step();
    rs = cyc;
  endtask

  // Reference model: a run starting (first active cycle) at rs with divisor d
  // ticks at rs + d/128, then every d/64 clocks; every 16th tick is a bit tick.
  task automatic add_segment(input int rs, input int re, input int d);
    int k;
    k = 0;
    for (int t = rs + d / 128; t <= re; t += d / 64) begin
      k++;
      exp_q.push_back(t);
      if (k % 16 == 0) exp_bit_q.push_back(t);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    cfg_valid = 1'b0;
    cfg_divisor = '0;
    cfg_enable = 1'b0;
    link_busy = 1'b0;
    step();
    checks++;
    if ({cfg_ready, cfg_err, active, pending, tick_16x, tick_bit} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_flags got %b exp 100000",
               {cfg_ready, cfg_err, active, pending, tick_16x, tick_bit});
    end
    checks++;
    if (cur_divisor !== 32'd256) begin
      errors++;
      $display("FAIL reset_divisor got %0d exp 256", cur_divisor);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int d, rs, n;
    for (int it = 0; it < 3; it++) begin
      do_reset();
      clear_obs();
      d = (it == 0) ? 256 : 128 * $urandom_range(2, 6);
      cfg_valid = 1'b1;
      cfg_divisor = d;
      cfg_enable = 1'b1;
      step();
      cfg_valid = 1'b0;
      checks++;
      if ({active, cfg_ready, pending} !== 3'b000) begin
        errors++;
        $display("FAIL basic_load got %b exp 000", {active, cfg_ready, pending});
      end
      step();
      rs = cyc;
      checks++;
      if ({active, cfg_ready} !== 2'b11) begin
        errors++;
        $display("FAIL basic_run got %b exp 11", {active, cfg_ready});
      end
      n = 17 * d / 64 + 4;
      steps(n);
      add_segment(rs, cyc, d);
      checks++;
      if (cur_divisor !== d) begin
        errors++;
        $display("FAIL basic_divisor got %0d exp %0d", cur_divisor, d);
      end
      checks++;
      if (got16.size() != exp_q.size() || gotb.size() != exp_bit_q.size()) begin
        errors++;
        $display("FAIL basic_tick_count d=%0d got %0d/%0d exp %0d/%0d", d,
                 got16.size(), gotb.size(), exp_q.size(), exp_bit_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got16.size(); i++) begin
        checks++;
        if (got16[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL basic_tick16 d=%0d idx %0d got %0d exp %0d", d, i, got16[i], exp_q[i]);
        end
      end
      for (int i = 0; i < exp_bit_q.size() && i < gotb.size(); i++) begin
        checks++;
        if (gotb[i] !== exp_bit_q[i]) begin
          errors++;
          $display("FAIL basic_tickbit d=%0d idx %0d got %0d exp %0d", d, i, gotb[i], exp_bit_q[i]);
        end
      end
    end
  endtask

  task automatic test_bad_div();
    int rs;
    do_reset();
    clear_obs();
    cfg_valid = 1'b1;
    cfg_divisor = $urandom_range(0, 255);
    cfg_enable = 1'b1;
    step();
    cfg_valid = 1'b0;
    checks++;
    if ({cfg_err, cfg_ready, active, pending} !== 4'b1100 || cur_divisor !== 32'd256) begin
      errors++;
      $display("FAIL bad_off got err/rdy/act/pend %b div %0d exp 1100 div 256",
               {cfg_err, cfg_ready, active, pending}, cur_divisor);
    end
    step();
    checks++;
    if (cfg_err !== 1'b0 || active !== 1'b0) begin
      errors++;
      $display("FAIL bad_off_after got err %b act %b exp 0 0", cfg_err, active);
    end
    start_run(256, 1'b0, rs);
    steps($urandom_range(10, 40));
    cfg_valid = 1'b1;
    cfg_divisor = $urandom_range(0, 255);
    cfg_enable = 1'b1;
    step();
    cfg_valid = 1'b0;
    checks++;
    if (cfg_err !== 1'b1 || active !== 1'b1 || pending !== 1'b0) begin
      errors++;
      $display("FAIL bad_run got err %b act %b pend %b exp 1 1 0", cfg_err, active, pending);
    end
    steps(80);
    add_segment(rs, cyc, 256);
    checks++;
    if (err_pulses != 2 || cur_divisor !== 32'd256) begin
      errors++;
      $display("FAIL bad_summary got pulses %0d div %0d exp 2 256", err_pulses, cur_divisor);
    end
    checks++;
    if (got16.size() != exp_q.size() || gotb.size() != exp_bit_q.size()) begin
      errors++;
      $display("FAIL bad_tick_count got %0d/%0d exp %0d/%0d",
               got16.size(), gotb.size(), exp_q.size(), exp_bit_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got16.size(); i++) begin
      checks++;
      if (got16[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL bad_tick16 idx %0d got %0d exp %0d", i, got16[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_wait_idle();
    int rs, rs2, w;
    do_reset();
    clear_obs();
    start_run(256, 1'b1, rs);
    steps(20);
    cfg_valid = 1'b1;
    cfg_divisor = 512;
    cfg_enable = 1'b1;
    step();
    cfg_valid = 1'b0;
    checks++;
    if ({pending, cfg_ready, active} !== 3'b101 || cur_divisor !== 32'd256) begin
      errors++;
      $display("FAIL wait_enter got pend/rdy/act %b div %0d exp 101 div 256",
               {pending, cfg_ready, active}, cur_divisor);
    end
    steps($urandom_range(10, 30));
    checks++;
    if (pending !== 1'b1) begin
      errors++;
      $display("FAIL wait_hold got pending %b exp 1", pending);
    end
    w = cyc;
    link_busy = 1'b0;
    step();
    checks++;
    if ({active, pending, cfg_ready} !== 3'b000) begin
      errors++;
      $display("FAIL wait_load got act/pend/rdy %b exp 000", {active, pending, cfg_ready});
    end
    step();
    rs2 = cyc;
    steps(300);
    add_segment(rs, w, 256);
    add_segment(rs2, cyc, 512);
    checks++;
    if (cur_divisor !== 32'd512 || active !== 1'b1) begin
      errors++;
      $display("FAIL wait_new_rate got div %0d act %b exp 512 1", cur_divisor, active);
    end
    checks++;
    if (got16.size() != exp_q.size() || gotb.size() != exp_bit_q.size()) begin
      errors++;
      $display("FAIL wait_tick_count got %0d/%0d exp %0d/%0d",
               got16.size(), gotb.size(), exp_q.size(), exp_bit_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got16.size(); i++) begin
      checks++;
      if (got16[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL wait_tick16 idx %0d got %0d exp %0d", i, got16[i], exp_q[i]);
      end
    end
    for (int i = 0; i < exp_bit_q.size() && i < gotb.size(); i++) begin
      checks++;
      if (gotb[i] !== exp_bit_q[i]) begin
        errors++;
        $display("FAIL wait_tickbit idx %0d got %0d exp %0d", i, gotb[i], exp_bit_q[i]);
      end
    end
  endtask

  task automatic test_disable();
    int rs, c;
    do_reset();
    clear_obs();
    start_run(256, 1'b0, rs);
    steps($urandom_range(20, 80));
    c = cyc;
    cfg_valid = 1'b1;
    cfg_divisor = 384;
    cfg_enable = 1'b0;
    step();
    cfg_valid = 1'b0;
    checks++;
    if ({active, cfg_ready, pending} !== 3'b010 || cur_divisor !== 32'd384) begin
      errors++;
      $display("FAIL disable_off got act/rdy/pend %b div %0d exp 010 div 384",
               {active, cfg_ready, pending}, cur_divisor);
    end
    steps(100);
    add_segment(rs, c, 256);
    checks++;
    if (got16.size() != exp_q.size() || gotb.size() != exp_bit_q.size()) begin
      errors++;
      $display("FAIL disable_tick_count got %0d/%0d exp %0d/%0d",
               got16.size(), gotb.size(), exp_q.size(), exp_bit_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got16.size(); i++) begin
      checks++;
      if (got16[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL disable_tick16 idx %0d got %0d exp %0d", i, got16[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_wait();
    int rs, n16, nb;
    logic saw_active;
    do_reset();
    clear_obs();
    start_run(256, 1'b1, rs);
    steps(10);
    cfg_valid = 1'b1;
    cfg_divisor = 512;
    cfg_enable = 1'b1;
    step();
    cfg_valid = 1'b0;
    steps(5);
    checks++;
    if (pending !== 1'b1) begin
      errors++;
      $display("FAIL rstwait_pending got %b exp 1", pending);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({pending, active, cfg_ready} !== 3'b001 || cur_divisor !== 32'd256) begin
      errors++;
      $display("FAIL rstwait_reset got pend/act/rdy %b div %0d exp 001 div 256",
               {pending, active, cfg_ready}, cur_divisor);
    end
    n16 = got16.size();
    nb = gotb.size();
    saw_active = 1'b0;
    link_busy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (active) saw_active = 1'b1;
    end
    checks++;
    if (saw_active !== 1'b0 || got16.size() != n16 || gotb.size() != nb || cur_divisor !== 32'd256) begin
      errors++;
      $display("FAIL rstwait_after got act %b ticks %0d bits %0d div %0d exp 0 0 0 256",
               saw_active, got16.size() - n16, gotb.size() - nb, cur_divisor);
    end
  endtask

  task automatic test_back_to_back();
    int phase_left, ticks_since, accepts, bits_seen;
    logic busy_lvl, prev_ready, prev_active, exp_bit;
    do_reset();
    clear_obs();
    cfg_valid = 1'b1;
    cfg_enable = 1'b1;
    busy_lvl = 1'b0;
    phase_left = 2;
    ticks_since = 0;
    accepts = 0;
    bits_seen = 0;
    prev_ready = cfg_ready;
    prev_active = active;
    for (int i = 0; i < 3000; i++) begin
      if (phase_left == 0) begin
        busy_lvl = ~busy_lvl;
        phase_left = busy_lvl ? $urandom_range(100, 400) : $urandom_range(1, 3);
      end
      phase_left--;
      link_busy = busy_lvl;
      cfg_divisor = $urandom_range(256, 512);
      step();
      if (prev_ready) begin
        accepts++;
        checks++;
        if (cfg_ready !== 1'b0) begin
          errors++;
          $display("FAIL b2b_one_accept cyc %0d got ready %b exp 0", cyc, cfg_ready);
        end
      end
      if (active && !prev_active) ticks_since = 0;
      if (tick_16x) ticks_since++;
      exp_bit = tick_16x && (ticks_since % 16 == 0);
      if (tick_16x || tick_bit) begin
        checks++;
        if (tick_bit !== exp_bit || !active) begin
          errors++;
          $display("FAIL b2b_tickbit cyc %0d got bit %b act %b exp bit %b act 1",
                   cyc, tick_bit, active, exp_bit);
        end
      end
      if (tick_bit) bits_seen++;
      prev_ready = cfg_ready;
      prev_active = active;
    end
    cfg_valid = 1'b0;
    checks++;
    if (bits_seen == 0 || accepts < 4 || err_pulses != 0) begin
      errors++;
      $display("FAIL b2b_activity got bits %0d accepts %0d errs %0d exp >0 >=4 0",
               bits_seen, accepts, err_pulses);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_div();
    test_wait_idle();
    test_disable();
    test_reset_wait();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
